// File: rtl/seq_divider_if.sv
// Start/busy/done handshake and operand/result bus
// for the iterative restoring divider.
interface seq_divider_if #(
  parameter int W = 4
);
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider.
// Produces one quotient bit per clock.
module seq_divider #(
  parameter int W = 4
) (
  input  logic        clk,
  input  logic        rst,
  seq_divider_if.slave bus
);
  localparam int CW = $clog2(W + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [W:0]    a;
  logic [W-1:0]  q;
  logic [W-1:0]  m;
  logic [W-1:0]  quo;
  logic [W-1:0]  rem;
  logic          dbz;

  logic [W:0]    a_sh;
  logic [W:0]    t;
  logic [W:0]    a_nx;
  logic [W-1:0]  q_nx;

  // One restoring step on the shifted {A,Q} pair
  always_comb begin
    a_sh = {a[W-1:0], q[W-1]};
    t    = a_sh - {1'b0, m};
    a_nx = t[W] ? a_sh : t;
    q_nx = {q[W-2:0], ~t[W]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      a     <= '0;
      q     <= '0;
      m     <= '0;
      quo   <= '0;
      rem   <= '0;
      dbz   <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          a   <= a_nx;
          q   <= q_nx;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= DONE;
            quo   <= q_nx;
            rem   <= a_nx[W-1:0];
            dbz   <= 1'b0;
          end
        end
        // IDLE and DONE both accept a new request
        default: begin
          if (bus.start) begin
            if (bus.divisor != '0) begin
              state <= RUN;
              cnt   <= CW'(W);
              a     <= '0;
              q     <= bus.dividend;
              m     <= bus.divisor;
            end else begin
              state <= DONE;
              quo   <= '1;
              rem   <= bus.dividend;
              dbz   <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.busy        = (state == RUN);
  assign bus.done        = (state == DONE);
  assign bus.quotient    = quo;
  assign bus.remainder   = rem;
  assign bus.div_by_zero = dbz;
endmodule

// File: tb/tb_seq_divider.sv
// Directed and exhaustive-sweep bench
// for seq_divider with W=4.
module tb_seq_divider;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  seq_divider_if #(.W(W)) bus ();

  seq_divider #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic run_div(
    input logic [W-1:0] dd,
    input logic [W-1:0] dv,
    input logic [W-1:0] eq,
    input logic [W-1:0] er,
    input logic         edbz,
    input int           elat,
    input string        name
  );
    int n;
    int bcnt;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = dd;
    bus.divisor  = dv;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n    = 0;
    bcnt = 0;
    while (!bus.done && n < 20) begin
      if (bus.busy) bcnt++;
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n !== elat) begin
      errors++;
      $display("FAIL %s latency: got %0d want %0d", name, n, elat);
    end
    checks++;
    if (bcnt !== elat) begin
      errors++;
      $display("FAIL %s busy cycles: got %0d want %0d", name, bcnt, elat);
    end
    checks++;
    if (bus.quotient !== eq || bus.remainder !== er || bus.div_by_zero !== edbz) begin
      errors++;
      $display("FAIL %s result: got q=%0d r=%0d dbz=%0b want q=%0d r=%0d dbz=%0b",
               name, bus.quotient, bus.remainder, bus.div_by_zero, eq, er, edbz);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s done pulse width: got done=%0b busy=%0b want 0 0",
               name, bus.done, bus.busy);
    end
    if (bus.quotient !== eq || bus.remainder !== er) begin
      errors++;
      $display("FAIL %s hold: got q=%0d r=%0d want q=%0d r=%0d",
               name, bus.quotient, bus.remainder, eq, er);
    end
    checks++;
  endtask

  task automatic test_reset();
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.quotient !== 4'd0 ||
        bus.remainder !== 4'd0 || bus.div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset: got busy=%0b done=%0b q=%0d r=%0d dbz=%0b want all 0",
               bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    run_div(4'd9,  4'd2, 4'd4, 4'd1, 1'b0, 4, "9/2");
    run_div(4'd15, 4'd15, 4'd1, 4'd0, 1'b0, 4, "15/15");
    run_div(4'd3,  4'd7, 4'd0, 4'd3, 1'b0, 4, "3/7");
    run_div(4'd0,  4'd5, 4'd0, 4'd0, 1'b0, 4, "0/5");
  endtask

  task automatic test_div_zero();
    run_div(4'd12, 4'd0, 4'hF, 4'd12, 1'b1, 0, "12/0");
    run_div(4'd12, 4'd3, 4'd4, 4'd0, 1'b0, 4, "12/3");
  endtask

  task automatic test_start_ignored();
    int n;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 4'd14;
    bus.divisor  = 4'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 4'd1;
    bus.divisor  = 4'd1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 2;
    while (!bus.done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL ignored-start latency: got %0d want 4", n);
    end
    checks++;
    if (bus.quotient !== 4'd4 || bus.remainder !== 4'd2) begin
      errors++;
      $display("FAIL ignored-start result: got q=%0d r=%0d want q=4 r=2",
               bus.quotient, bus.remainder);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL ignored-start restarted: got done=%0b busy=%0b want 0 0",
               bus.done, bus.busy);
    end
  endtask

  task automatic test_reset_mid_run();
    bit seen_done;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 4'd13;
    bus.divisor  = 4'd4;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.quotient !== 4'd0 ||
        bus.remainder !== 4'd0 || bus.div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL mid-run reset: got busy=%0b done=%0b q=%0d r=%0d dbz=%0b want all 0",
               bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero);
    end
    seen_done = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.done) seen_done = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.done) seen_done = 1'b1;
    end
    checks++;
    if (seen_done !== 1'b0) begin
      errors++;
      $display("FAIL mid-run reset done: got 1 want 0");
    end
    run_div(4'd13, 4'd4, 4'd3, 4'd1, 1'b0, 4, "13/4 after reset");
  endtask

  task automatic test_back_to_back();
    logic [7:0]   idx;
    logic [W-1:0] dd;
    logic [W-1:0] dv;
    logic [W-1:0] eq;
    logic [W-1:0] er;
    int           n;
    int           elat;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 4'd0;
    bus.divisor  = 4'd0;
    @(posedge clk); #1;
    for (int i = 0; i < 256; i++) begin
      idx = i[7:0];
      dd  = idx[7:4];
      dv  = idx[3:0];
      if (dv == 4'd0) begin
        eq   = 4'hF;
        er   = dd;
        elat = 0;
      end else begin
        eq   = dd / dv;
        er   = dd % dv;
        elat = W;
      end
      idx = idx + 8'd1;
      bus.dividend = idx[7:4];
      bus.divisor  = idx[3:0];
      n = 0;
      while (!bus.done && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      checks++;
      if (n !== elat) begin
        errors++;
        $display("FAIL b2b %0d/%0d latency: got %0d want %0d", dd, dv, n, elat);
      end
      checks++;
      if (bus.quotient !== eq || bus.remainder !== er ||
          bus.div_by_zero !== (dv == 4'd0)) begin
        errors++;
        $display("FAIL b2b %0d/%0d result: got q=%0d r=%0d dbz=%0b want q=%0d r=%0d dbz=%0b",
                 dd, dv, bus.quotient, bus.remainder, bus.div_by_zero,
                 eq, er, (dv == 4'd0));
      end
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    repeat (8) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_start_ignored();
    test_reset_mid_run();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
